// File: rtl/bram_dump_reader_pkg.sv
// Shared definitions for the BRAM readback engine: FSM state encoding and
// default data width of the RV32I memory subsystem.
package bram_dump_reader_pkg;

    localparam int DUMP_DATA_WIDTH = 32;
    localparam int DUMP_WORD_BYTES = 4;

    typedef enum logic [2:0] {
        DUMP_IDLE  = 3'd0,
        DUMP_ISSUE = 3'd1,
        DUMP_WAIT  = 3'd2,
        DUMP_SEND  = 3'd3,
        DUMP_DONE  = 3'd4
    } dump_state_t;

endpackage

// File: rtl/bram_dump_reader.sv
// Sequentially reads a word-aligned window of a 32-bit BRAM through its debug
// port and streams each word to the host over a valid/ready handshake.
module bram_dump_reader
    import bram_dump_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = DUMP_DATA_WIDTH,
    parameter int CNT_WIDTH  = 9,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    // A combinational debug port lets ISSUE capture the word directly.
    localparam bit COMB_READ = (RD_LATENCY == 0);

    dump_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [CNT_WIDTH-1:0]  r_remaining;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_rd_en;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_done;

    logic [ADDR_WIDTH-1:0] w_base_aligned;
    logic                  w_last_word;
    logic                  w_handshake;
    logic                  w_unused_base_lsbs;

    assign w_base_aligned     = {base_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_last_word        = (r_remaining == CNT_WIDTH'(1));
    assign w_handshake        = r_valid & m_ready;
    assign w_unused_base_lsbs = &{1'b0, base_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= DUMP_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_rd_en     <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                DUMP_IDLE: begin
                    if (start) begin
                        r_cur_addr  <= w_base_aligned;
                        r_remaining <= word_count;
                        r_busy      <= 1'b1;
                        if (word_count == '0) begin
                            r_state <= DUMP_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= DUMP_ISSUE;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                DUMP_ISSUE: begin
                    r_rd_en <= 1'b0;
                    if (COMB_READ) begin
                        r_data  <= mem_rd_data;
                        r_valid <= 1'b1;
                        r_last  <= w_last_word;
                        r_state <= DUMP_SEND;
                    end else begin
                        r_state <= DUMP_WAIT;
                    end
                end
                DUMP_WAIT: begin
                    r_data  <= mem_rd_data;
                    r_valid <= 1'b1;
                    r_last  <= w_last_word;
                    r_state <= DUMP_SEND;
                end
                DUMP_SEND: begin
                    // Everything holds until the host takes the word.
                    if (w_handshake) begin
                        r_valid     <= 1'b0;
                        r_last      <= 1'b0;
                        r_remaining <= r_remaining - CNT_WIDTH'(1);
                        r_cur_addr  <= r_cur_addr + ADDR_WIDTH'(DUMP_WORD_BYTES);
                        if (w_last_word) begin
                            r_state <= DUMP_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= DUMP_ISSUE;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                DUMP_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= DUMP_IDLE;
                end
                default: begin
                    r_state <= DUMP_IDLE;
                end
            endcase
        end
    end

    // The address counter doubles as the BRAM address, so it is stable in SEND.
    assign mem_addr  = r_cur_addr;
    assign mem_rd_en = r_rd_en;
    assign m_valid   = r_valid;
    assign m_data    = r_data;
    assign m_last    = r_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_bram_dump_reader.sv
// Bench for bram_dump_reader: a registered-read and a combinational-read
// instance run side by side against an array-based reference of the dump.
module tb_bram_dump_reader;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 9;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic [9:0]  a;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          m_ready;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic [DW-1:0] mem [0:255];

    logic [AW-1:0] a1, a0;
    logic          rd1, rd0;
    logic [DW-1:0] rdd1, rdd0;
    logic          v1, v0;
    logic [DW-1:0] d1, d0;
    logic          l1, l0;
    logic          busy1, busy0;
    logic          done1, done0;

    int n_checks = 0;
    int n_err    = 0;

    beat_t q1[$];
    beat_t q0[$];
    int    n_done [2];
    int    n_busy [2];
    int    n_rden [2];
    logic  pv [2];
    logic [31:0] pd [2];
    logic  pl [2];
    logic [9:0] pa [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rdd1 <= mem[a1[9:2]];
    assign rdd0 = mem[a0[9:2]];

    bram_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .RD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .mem_addr(a1), .mem_rd_en(rd1), .mem_rd_data(rdd1),
        .m_valid(v1), .m_ready(m_ready), .m_data(d1), .m_last(l1),
        .busy(busy1), .done(done1)
    );

    bram_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .RD_LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .mem_addr(a0), .mem_rd_en(rd0), .mem_rd_data(rdd0),
        .m_valid(v0), .m_ready(m_ready), .m_data(d0), .m_last(l0),
        .busy(busy0), .done(done0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle observation of one instance, sampled on the falling edge.
    task automatic mon(input int k, input logic v, input logic [31:0] d, input logic l,
                       input logic [9:0] a, input logic rd, input logic bz, input logic dn);
        beat_t b;
        if (rst) begin
            pv[k] = 1'b0;
            return;
        end
        if (pv[k]) begin
            check($sformatf("L%0d hold_valid", k), v, 1);
            check($sformatf("L%0d hold_data", k), d, pd[k]);
            check($sformatf("L%0d hold_last", k), l, pl[k]);
            check($sformatf("L%0d hold_addr", k), a, pa[k]);
        end
        if (v) check($sformatf("L%0d valid_needs_busy", k), bz, 1);
        if (v && m_ready) begin
            b = '{d: d, l: l, a: a};
            if (k == 1) q1.push_back(b);
            else        q0.push_back(b);
        end
        if (dn) n_done[k]++;
        if (bz) n_busy[k]++;
        if (rd) n_rden[k]++;
        pv[k] = v && !m_ready;
        pd[k] = d;
        pl[k] = l;
        pa[k] = a;
    endtask

    always @(negedge clk) begin
        mon(1, v1, d1, l1, a1, rd1, busy1, done1);
        mon(0, v0, d0, l0, a0, rd0, busy0, done0);
    end

    task automatic clear_obs();
        q1.delete();
        q0.delete();
        for (int k = 0; k < 2; k++) begin
            n_done[k] = 0;
            n_busy[k] = 0;
            n_rden[k] = 0;
        end
    endtask

    // Reference: word i of the dump comes from word index (base/4 + i) mod 256.
    task automatic compare(input int k, input int base, input int n);
        beat_t b;
        int    sz;
        int    w;
        sz = (k == 1) ? q1.size() : q0.size();
        check($sformatf("L%0d beat_count", k), sz, n);
        for (int i = 0; i < n && i < sz; i++) begin
            b = (k == 1) ? q1[i] : q0[i];
            w = ((base >> 2) + i) % 256;
            check($sformatf("L%0d data[%0d]", k, i), b.d, mem[w]);
            check($sformatf("L%0d last[%0d]", k, i), b.l, (i == n - 1) ? 1 : 0);
            check($sformatf("L%0d addr[%0d]", k, i), b.a, w * 4);
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: stall after the first L1 beat.
    task automatic do_dump(input int base, input int n, input int mode, input int restart_at);
        int cyc;
        int stall;
        clear_obs();
        base_addr  = AW'(base);
        word_count = CW'(n);
        m_ready    = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        stall = 0;
        while ((busy1 || busy0) && cyc < 4000) begin
            if (mode == 1) begin
                m_ready = ($urandom_range(0, 3) != 0);
            end else if (mode == 2) begin
                m_ready = !(q1.size() == 1 && stall < 7);
                if (!m_ready) stall++;
            end
            start = (cyc == restart_at) && busy1 && busy0;
            tick();
            cyc++;
        end
        start   = 1'b0;
        m_ready = 1'b1;
        check("dump_timeout", (cyc < 4000) ? 1 : 0, 1);
        repeat (4) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("L%0d done_pulses", k), n_done[k], 1);
            check($sformatf("L%0d rd_en_cycles", k), n_rden[k], n);
            if (mode == 0)
                check($sformatf("L%0d busy_cycles", k), n_busy[k], ((k == 1) ? 3 : 2) * n + 1);
            compare(k, base, n);
        end
        check("L1 busy_after", busy1, 0);
        check("L0 busy_after", busy0, 0);
        $display("dump base=%03h count=%0d mode=%0d beats L1=%0d L0=%0d errors=%0d",
                 base, n, mode, q1.size(), q0.size(), n_err);
    endtask

    task automatic reset_mid_dump();
        int cyc;
        clear_obs();
        m_ready    = 1'b0;
        base_addr  = '0;
        word_count = CW'(4);
        start      = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (!(v1 && v0) && cyc < 50) begin
            tick();
            cyc++;
        end
        check("rst_reach_send", (v1 && v0) ? 1 : 0, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        repeat (6) tick();
        check("L1 beat2_pending", v1, 1);
        check("L0 beat2_pending", v0, 1);
        rst = 1'b1;
        tick();
        check("L1 rst_valid", v1, 0);
        check("L0 rst_valid", v0, 0);
        check("L1 rst_busy", busy1, 0);
        check("L0 rst_busy", busy0, 0);
        check("L1 rst_done", done1, 0);
        check("L0 rst_done", done0, 0);
        check("L1 rst_addr", a1, 0);
        check("L0 rst_addr", a0, 0);
        rst = 1'b0;
        m_ready = 1'b1;
        repeat (3) tick();
        check("L1 rst_no_done", n_done[1], 0);
        check("L0 rst_no_done", n_done[0], 0);
        check("L1 rst_beats", q1.size(), 1);
        check("L0 rst_beats", q0.size(), 1);
        if (q1.size() > 0) check("L1 rst_beat1", q1[0].d, mem[0]);
        if (q0.size() > 0) check("L0 rst_beat1", q0[0].d, mem[0]);
        $display("reset mid-dump beats L1=%0d L0=%0d errors=%0d", q1.size(), q0.size(), n_err);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        m_ready    = 1'b0;
        base_addr  = '0;
        word_count = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) tick();
        check("L1 reset_valid", v1, 0);
        check("L0 reset_valid", v0, 0);
        check("L1 reset_busy", busy1, 0);
        check("L0 reset_busy", busy0, 0);
        check("L1 reset_done", done1, 0);
        check("L0 reset_done", done0, 0);
        check("L1 reset_addr", a1, 0);
        check("L0 reset_addr", a0, 0);
        check("L1 reset_data", d1, 0);
        check("L0 reset_data", d0, 0);
        check("L1 reset_last", l1, 0);
        check("L1 reset_rd_en", rd1, 0);
        rst = 1'b0;
        tick();

        mem[0] = 32'h00000001;
        mem[1] = 32'h00000002;
        mem[2] = 32'h00000003;
        mem[3] = 32'h00000003;
        do_dump(32'h000, 4, 0, -1);
        do_dump(32'h000, 4, 2, -1);

        mem[255] = 32'hDEADBEEF;
        do_dump(32'h3FC, 2, 0, -1);

        do_dump(32'h000, 0, 0, -1);
        do_dump(32'h000, 4, 0, 3);

        reset_mid_dump();
        do_dump(32'h008, 1, 0, -1);

        do_dump(32'h10B, 6, 1, -1);
        do_dump(32'h100, 260, 0, -1);

        for (int t = 0; t < 24; t++) begin
            do_dump(int'($urandom_range(0, 1023)), int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 8)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
